drm_wr_arb_ctrl: RTL
====================

Name: drm_wr_arb_ctrl

Overview:
Sequencer/arbiter for a 17x256 simple-dual-port DRM (wr_data/wr_addr/wr_en, rd_addr/rd_data). It shares the single RAM write port between two requesters with round-robin fairness and serves one read requester with a valid/ready front end. It also runs a clear engine that zero-fills the array after reset or on command. Everything runs on wr_clk; the integrator ties the RAM rd_clk to wr_clk.

Parameters:
ADDR_WIDTH, 8, RAM address width (depth 2**ADDR_WIDTH).
DATA_WIDTH, 17, RAM data width.
RD_LATENCY, 1, RAM read latency in cycles: 1 when the RAM has no output register, 2 when it does. Legal values are 1 and 2.
CLR_ON_RST, 1, 1 = clear engine starts automatically when reset releases.

Ports:
wr_clk  in  1  single clock for the block and for both RAM ports.
tb_wr_rst  in  1  asynchronous, active-high reset.
clr_start  in  1  pulse; requests a full zero-fill.
clr_busy  out  1  high while the clear engine owns the write port.
w0_valid / w1_valid  in  1  write request, port 0 / port 1.
w0_ready / w1_ready  out  1  write grant; transfer when valid&&ready.
w0_addr / w1_addr  in  ADDR_WIDTH  write address.
w0_data / w1_data  in  DATA_WIDTH  write data.
r_valid  in  1  read request.
r_ready  out  1  read accepted when r_valid&&r_ready.
r_addr  in  ADDR_WIDTH  read address.
rsp_valid  out  1  read data valid.
rsp_data  out  DATA_WIDTH  read data.
ram_wr_en  out  1  to RAM wr_en.
ram_wr_addr  out  ADDR_WIDTH  to RAM wr_addr.
ram_wr_data  out  DATA_WIDTH  to RAM wr_data.
ram_rd_addr  out  ADDR_WIDTH  to RAM rd_addr.
ram_rd_data  in  DATA_WIDTH  from RAM rd_data.

Behaviour:
- Reset values: clr_busy=CLR_ON_RST, ram_wr_en=0, ram_wr_addr=0, ram_wr_data=0, ram_rd_addr=0, rsp_valid=0, rsp_data=0, w0_ready=w1_ready=r_ready=0. Round-robin pointer resets to favour port 0.
- FSM states are CLEAR and RUN. Reset enters CLEAR when CLR_ON_RST=1, otherwise RUN.
- CLEAR:
  - Each cycle: ram_wr_en=1, ram_wr_data=0, ram_wr_addr=clr_cnt; clr_cnt increments.
  - After address 2**ADDR_WIDTH-1 is written, go to RUN. A clear takes exactly 256 cycles at the default.
  - w*_ready=0 and r_ready=0 throughout.
- RUN:
  - clr_start=1 -> CLEAR next cycle with clr_cnt=0. Requests in that same cycle are still arbitrated normally.
  - clr_start while already in CLEAR is ignored; no restart.
- Write arbitration (RUN only), combinational ready:
  - One valid -> that port is granted.
  - Both valid -> grant the port the pointer favours. The pointer moves to the other port after any granted transfer by the favoured port.
  - No more than one grant per cycle.
  - Granted request is registered onto ram_wr_* one cycle after the handshake. ram_wr_en=1 for exactly one cycle per transfer.
- Read path (RUN only):
  - r_ready=1 except during a same-address hazard: a registered write is pending this cycle to r_addr. In that case r_ready=0 for one cycle.
  - An accepted read registers ram_rd_addr.
  - rsp_valid and rsp_data = ram_rd_data appear RD_LATENCY cycles after ram_rd_addr updates, i.e. RD_LATENCY+1 cycles after the handshake. This timing comes from a valid shift register of depth RD_LATENCY.
  - Back-to-back reads: one per cycle, fully pipelined. There is no response backpressure.
- Reads and writes to different addresses proceed in the same cycle.
- Reset mid-operation (either state) aborts immediately:
  - in-flight rsp_valid is dropped;
  - a partially cleared array is not completed unless CLR_ON_RST=1, in which case the clear restarts from address 0.
- Address wrap: clr_cnt is ADDR_WIDTH+1 bits; the MSB marks done. Requester addresses are used as-is.

Decomposition:
- Shared package drm_ctrl_pkg: state enum {CLEAR, RUN}, default widths, RD_LATENCY legality check.
- One sub-module, drm_rr_arb2: 2-input round-robin arbiter (valid in, grant out, pointer update on transfer).

Test Plan:
- Reset release with CLR_ON_RST=1 -> clr_busy high 256 cycles; ram_wr_en=1 with data 0 at addresses 0..255; then RUN, w0_ready=1.
- Write 17'h1FFFF to addr 8'h05 via port 0, then read addr 8'h05 (RD_LATENCY=1) -> rsp_valid exactly 2 cycles after the read handshake, rsp_data=17'h1FFFF.
- Both ports valid for 6 cycles -> grants alternate 0,1,0,1,0,1; ram_wr_en high 6 cycles consecutively.
- Write addr 8'h10 handshake in cycle N, read addr 8'h10 presented in cycle N+1 -> r_ready=0 in N+1, read accepted N+2, returns the new data.
- clr_start in RUN after filling 8'h00..8'h03 with 17'h00AAA -> 256 clear cycles; subsequent reads of 8'h00..8'h03 return 0. clr_start mid-clear does not extend the 256 cycles.
- Assert tb_wr_rst at clear count 100 -> all outputs to reset values immediately; after release, clear restarts at address 0 and runs 256 cycles.

Source files
------------

// File: rtl/drm_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// drm_ctrl_pkg
// Shared definitions for the DRM write-arbiter / sequencer slice.
//   - drm_state_e    : top-level sequencer states (CLEAR, RUN)
//   - DRM_*          : default geometry of the 17x256 simple-dual-port DRM
//   - rd_latency_ok  : legality check for the RAM read latency parameter
// -----------------------------------------------------------------------------
package drm_ctrl_pkg;

  // Sequencer states: CLEAR owns the RAM write port, RUN serves requesters.
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } drm_state_e;

  localparam int DRM_ADDR_WIDTH = 8;
  localparam int DRM_DATA_WIDTH = 17;
  localparam int DRM_RD_LATENCY = 1;

  // Only RAMs without (1) or with (2) an output register are supported.
  function automatic bit rd_latency_ok(input int lat);
    return (lat == 32'sd1) || (lat == 32'sd2);
  endfunction

endpackage

// File: rtl/drm_rr_arb2.sv
// -----------------------------------------------------------------------------
// drm_rr_arb2
// Two-input round-robin arbiter with a combinational grant.
// Ports:
//   clk_i    in   clock
//   rst_i    in   asynchronous active-high reset (pointer favours input 0)
//   en_i     in   arbitration enable; no grant while low
//   valid_i  in   [1:0] request vector
//   grant_o  out  [1:0] one-hot (or zero) grant; a grant is a transfer
// The pointer names the favoured input. It only moves when the favoured
// input wins, so a lone request from the other side does not steal its turn.
// -----------------------------------------------------------------------------
module drm_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] valid_i,
  output logic [1:0] grant_o
);

  logic       ptr_q;
  logic       ptr_d;
  logic [1:0] grant_s;

  // Grant selection and pointer next-state.
  always_comb begin
    grant_s = 2'b00;
    if (en_i) begin
      case (valid_i)
        2'b01:   grant_s = 2'b01;
        2'b10:   grant_s = 2'b10;
        2'b11:   grant_s = ptr_q ? 2'b10 : 2'b01;
        default: grant_s = 2'b00;
      endcase
    end else begin
      grant_s = 2'b00;
    end

    if (grant_s[ptr_q]) begin
      ptr_d = ~ptr_q;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign grant_o = grant_s;

endmodule

// File: rtl/drm_wr_arb_ctrl.sv
// -----------------------------------------------------------------------------
// drm_wr_arb_ctrl
// Sequencer / arbiter in front of a simple-dual-port DRM (default 17x256).
// Shares the single RAM write port between two requesters (round robin),
// serves one read requester through valid/ready, and zero-fills the array
// after reset (CLR_ON_RST) or on clr_start. Everything runs on wr_clk; the
// RAM read clock is tied to wr_clk by the integrator.
// Ports:
//   wr_clk, tb_wr_rst           clock, asynchronous active-high reset
//   clr_start / clr_busy        clear request pulse / clear engine active
//   w0_*, w1_*                  write requesters (valid/ready/addr/data)
//   r_valid/r_ready/r_addr      read request front end
//   rsp_valid/rsp_data          read response (no backpressure)
//   ram_wr_en/addr/data         registered RAM write port
//   ram_rd_addr / ram_rd_data   registered RAM read address / RAM read data
// -----------------------------------------------------------------------------
module drm_wr_arb_ctrl
  import drm_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DRM_ADDR_WIDTH,
  parameter int DATA_WIDTH = DRM_DATA_WIDTH,
  parameter int RD_LATENCY = DRM_RD_LATENCY,
  parameter bit CLR_ON_RST = 1'b1
) (
  input  logic                  wr_clk,
  input  logic                  tb_wr_rst,
  input  logic                  clr_start,
  output logic                  clr_busy,
  input  logic                  w0_valid,
  output logic                  w0_ready,
  input  logic [ADDR_WIDTH-1:0] w0_addr,
  input  logic [DATA_WIDTH-1:0] w0_data,
  input  logic                  w1_valid,
  output logic                  w1_ready,
  input  logic [ADDR_WIDTH-1:0] w1_addr,
  input  logic [DATA_WIDTH-1:0] w1_data,
  input  logic                  r_valid,
  output logic                  r_ready,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  // An illegal read latency falls back to the unregistered-RAM timing.
  localparam int         RD_LAT    = rd_latency_ok(RD_LATENCY) ? RD_LATENCY : 1;
  localparam drm_state_e RST_STATE = CLR_ON_RST ? CLEAR : RUN;

  drm_state_e            state_q;
  logic [ADDR_WIDTH:0]   clr_cnt_q;       // MSB of the incremented value marks done
  logic [ADDR_WIDTH:0]   clr_cnt_inc_s;
  logic                  clr_busy_q;
  logic                  run_q;           // qualifies all readies; low in reset
  logic                  ram_wr_en_q;
  logic [ADDR_WIDTH-1:0] ram_wr_addr_q;
  logic [DATA_WIDTH-1:0] ram_wr_data_q;
  logic [ADDR_WIDTH-1:0] ram_rd_addr_q;

  logic [1:0]            grant_s;
  logic [ADDR_WIDTH-1:0] wr_addr_sel_s;
  logic [DATA_WIDTH-1:0] wr_data_sel_s;
  logic                  wr_hazard_s;
  logic                  r_ready_s;
  logic                  rd_acc_s;
  logic                  rd_pend_q;       // read address is on ram_rd_addr this cycle
  logic [RD_LAT-1:0]     rd_vld_q;
  logic [RD_LAT-1:0]     rd_vld_d_s;
  logic [DATA_WIDTH-1:0] rsp_data_s;

  drm_rr_arb2 u_arb (
    .clk_i   (wr_clk),
    .rst_i   (tb_wr_rst),
    .en_i    (run_q),
    .valid_i ({w1_valid, w0_valid}),
    .grant_o (grant_s)
  );

  // Write mux, read hazard detection, read acceptance and response shift.
  always_comb begin
    clr_cnt_inc_s = clr_cnt_q + {{ADDR_WIDTH{1'b0}}, 1'b1};

    if (grant_s[1]) begin
      wr_addr_sel_s = w1_addr;
      wr_data_sel_s = w1_data;
    end else begin
      wr_addr_sel_s = w0_addr;
      wr_data_sel_s = w0_data;
    end

    // A write already registered onto the RAM port lands at the end of this
    // cycle; holding the same-address read one cycle returns the new data.
    wr_hazard_s = ram_wr_en_q && (ram_wr_addr_q == r_addr);
    if (run_q && !wr_hazard_s) begin
      r_ready_s = 1'b1;
    end else begin
      r_ready_s = 1'b0;
    end
    rd_acc_s = r_valid && r_ready_s;

    rd_vld_d_s    = '0;
    rd_vld_d_s[0] = rd_pend_q;
    for (int i = 1; i < RD_LAT; i++) begin
      rd_vld_d_s[i] = rd_vld_q[i-1];
    end

    // Response data is the RAM output itself, qualified by the valid pipe.
    if (rd_vld_q[RD_LAT-1]) begin
      rsp_data_s = ram_rd_data;
    end else begin
      rsp_data_s = '0;
    end
  end

  // Sequencer FSM: clear engine, write-port ownership and registered write port.
  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) begin
      state_q       <= RST_STATE;
      clr_cnt_q     <= '0;
      clr_busy_q    <= CLR_ON_RST;
      run_q         <= 1'b0;
      ram_wr_en_q   <= 1'b0;
      ram_wr_addr_q <= '0;
      ram_wr_data_q <= '0;
    end else begin
      case (state_q)
        CLEAR: begin
          ram_wr_en_q   <= 1'b1;
          ram_wr_addr_q <= clr_cnt_q[ADDR_WIDTH-1:0];
          ram_wr_data_q <= '0;
          // clr_start is ignored here: a running clear is never restarted.
          if (clr_cnt_inc_s[ADDR_WIDTH]) begin
            state_q    <= RUN;
            clr_cnt_q  <= '0;
            clr_busy_q <= 1'b0;
            run_q      <= 1'b1;
          end else begin
            state_q    <= CLEAR;
            clr_cnt_q  <= clr_cnt_inc_s;
            clr_busy_q <= 1'b1;
            run_q      <= 1'b0;
          end
        end
        RUN: begin
          // The grant of the clr_start cycle is still carried out.
          ram_wr_en_q <= |grant_s;
          if (|grant_s) begin
            ram_wr_addr_q <= wr_addr_sel_s;
            ram_wr_data_q <= wr_data_sel_s;
          end else begin
            ram_wr_addr_q <= ram_wr_addr_q;
            ram_wr_data_q <= ram_wr_data_q;
          end
          clr_cnt_q <= '0;
          if (clr_start) begin
            state_q    <= CLEAR;
            clr_busy_q <= 1'b1;
            run_q      <= 1'b0;
          end else begin
            state_q    <= RUN;
            clr_busy_q <= 1'b0;
            run_q      <= 1'b1;
          end
        end
        default: begin
          state_q       <= RST_STATE;
          clr_cnt_q     <= '0;
          clr_busy_q    <= CLR_ON_RST;
          run_q         <= 1'b0;
          ram_wr_en_q   <= 1'b0;
          ram_wr_addr_q <= ram_wr_addr_q;
          ram_wr_data_q <= ram_wr_data_q;
        end
      endcase
    end
  end

  // Read address register and response-valid shift register.
  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) begin
      ram_rd_addr_q <= '0;
      rd_pend_q     <= 1'b0;
      rd_vld_q      <= '0;
    end else begin
      if (rd_acc_s) begin
        ram_rd_addr_q <= r_addr;
      end else begin
        ram_rd_addr_q <= ram_rd_addr_q;
      end
      rd_pend_q <= rd_acc_s;
      rd_vld_q  <= rd_vld_d_s;
    end
  end

  assign clr_busy    = clr_busy_q;
  assign w0_ready    = grant_s[0];
  assign w1_ready    = grant_s[1];
  assign r_ready     = r_ready_s;
  assign rsp_valid   = rd_vld_q[RD_LAT-1];
  assign rsp_data    = rsp_data_s;
  assign ram_wr_en   = ram_wr_en_q;
  assign ram_wr_addr = ram_wr_addr_q;
  assign ram_wr_data = ram_wr_data_q;
  assign ram_rd_addr = ram_rd_addr_q;

endmodule
